// File: rtl/pwl_euler_core_pkg.sv
// Shared Q2.13 fixed-point constants, FSM encoding and the saturation helper
// for the piecewise-linear jerk-system Euler core.
package pwl_euler_core_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 13;
  localparam int WIDE  = 2 * WIDTH;
  localparam int FW    = WIDTH + 3;
  localparam int ONE   = 1 << FRAC;

  localparam logic signed [WIDTH-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [WIDTH-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC1,
    ST_CALC2,
    ST_UPDATE,
    ST_HOLD
  } state_t;

  // Clamp a full-precision intermediate into the Width-bit state range.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDE-1:0] v);
    if (v > WIDE'(SAT_MAX)) return SAT_MAX;
    else if (v < WIDE'(SAT_MIN)) return SAT_MIN;
    else return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pwl_euler_core_fx_mul_sat.sv
// Signed Q-format multiply: full-precision product, floor shift by FRAC,
// then saturate back to WIDTH bits.
module fx_mul_sat
  import pwl_euler_core_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [WIDE-1:0] prod;
  logic signed [WIDE-1:0] shifted;

  always_comb begin
    prod    = WIDE'(a) * WIDE'(b);
    shifted = prod >>> FRAC;
    p       = sat_w(shifted);
  end

endmodule

// File: rtl/pwl_euler_core.sv
// Forward-Euler iterator for x' = y, y' = z, z' = -A*z - y + |x| - 1,
// presenting each (x, y, z) sample on a valid/ready port.
module pwl_euler_core
  import pwl_euler_core_pkg::*;
#(
  parameter logic signed [WIDTH-1:0] CoefA = 16'sd4915,
  parameter logic signed [WIDTH-1:0] StepH = 16'sd128
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    run_i,
  input  logic signed [WIDTH-1:0] x0_i,
  input  logic signed [WIDTH-1:0] y0_i,
  input  logic signed [WIDTH-1:0] z0_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o,
  output logic        [WIDTH-1:0] count_o,
  output logic                    busy_o
);

  // Handshake: a sample moves when valid_o && ready_i at a rising edge; while
  // valid_o is high and ready_i low, valid_o and x_o/y_o/z_o hold steady.
  state_t state, state_next;

  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic        [WIDTH-1:0] count_q;
  logic signed [WIDTH-1:0] p_az_q, abs_x_q, f_q, hy_q, hz_q;
  logic signed [WIDTH-1:0] m_az, m_hy, m_hz, m_hf;
  logic signed [WIDTH-1:0] abs_x_c;
  logic signed [FW-1:0]    f_sum;

  fx_mul_sat u_mul_az (.a(CoefA), .b(z_q), .p(m_az));
  fx_mul_sat u_mul_hy (.a(StepH), .b(y_q), .p(m_hy));
  fx_mul_sat u_mul_hz (.a(StepH), .b(z_q), .p(m_hz));
  fx_mul_sat u_mul_hf (.a(StepH), .b(f_q), .p(m_hf));

  always_comb begin
    abs_x_c = x_q;
    if (x_q == SAT_MIN) abs_x_c = SAT_MAX;
    else if (x_q[WIDTH-1]) abs_x_c = -x_q;
    f_sum = -FW'(p_az_q) - FW'(y_q) + FW'(abs_x_q) - FW'(ONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else state <= state_next;
  end

  // LOAD goes straight to HOLD so the initial conditions are sample 0.
  always_comb begin
    state_next = state;
    if (start_i) begin
      state_next = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_IDLE;
        ST_LOAD:   state_next = ST_HOLD;
        ST_CALC1:  state_next = ST_CALC2;
        ST_CALC2:  state_next = ST_UPDATE;
        ST_UPDATE: state_next = ST_HOLD;
        ST_HOLD:   if (ready_i) state_next = run_i ? ST_CALC1 : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_o = (state == ST_HOLD);
    busy_o  = (state != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      count_q <= '0;
      p_az_q  <= '0;
      abs_x_q <= '0;
      f_q     <= '0;
      hy_q    <= '0;
      hz_q    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          x_q     <= x0_i;
          y_q     <= y0_i;
          z_q     <= z0_i;
          count_q <= '0;
        end
        ST_CALC1: begin
          p_az_q  <= m_az;
          abs_x_q <= abs_x_c;
        end
        ST_CALC2: begin
          f_q  <= sat_w(WIDE'(f_sum));
          hy_q <= m_hy;
          hz_q <= m_hz;
        end
        ST_UPDATE: begin
          x_q <= sat_w(WIDE'(x_q) + WIDE'(hy_q));
          y_q <= sat_w(WIDE'(y_q) + WIDE'(hz_q));
          z_q <= sat_w(WIDE'(z_q) + WIDE'(m_hf));
        end
        ST_HOLD: begin
          if (ready_i) count_q <= count_q + WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_pwl_euler_core.sv
// Directed bench for pwl_euler_core: table of first-step vectors plus
// hand-written backpressure, restart, run-low and reset sequences.
module tb_pwl_euler_core;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic               run_i = 1'b0;
  logic signed [15:0] x0_i = '0, y0_i = '0, z0_i = '0;
  logic               ready_i = 1'b0;
  logic               valid_o;
  logic signed [15:0] x_o, y_o, z_o;
  logic        [15:0] count_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  typedef struct {
    logic signed [15:0] x0, y0, z0;
    logic signed [15:0] s1x, s1y, s1z;
  } vec_t;
  vec_t vecs[5];

  pwl_euler_core dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .run_i(run_i),
    .x0_i(x0_i), .y0_i(y0_i), .z0_i(z0_i), .ready_i(ready_i),
    .valid_o(valid_o), .x_o(x_o), .y_o(y_o), .z_o(z_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // scoreboard: every transfer must match the next expected sample
  always @(negedge clk) begin
    if (!rst_i && valid_o === 1'b1 && ready_i) begin
      logic [47:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer actual (%0d,%0d,%0d) required none", x_o, y_o, z_o);
      end else begin
        e = exp_q.pop_front();
        if ({x_o, y_o, z_o} !== e) begin
          errors++;
          $display("FAIL sample actual (%0d,%0d,%0d) required (%0d,%0d,%0d)", x_o, y_o, z_o,
                   $signed(e[47:32]), $signed(e[31:16]), $signed(e[15:0]));
        end
      end
    end
  end

  // driver tasks; callers sit at posedge+1
  task automatic start_load(input logic signed [15:0] x0, input logic signed [15:0] y0,
                            input logic signed [15:0] z0);
    start_i = 1'b1;
    x0_i = x0;
    y0_i = y0;
    z0_i = z0;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid_o !== 1'b1 && lat < 20);
    check(name, lat, exp_lat);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{16'sd0,      -16'sd5734,  16'sd0,      -16'sd90,    -16'sd5734,  -16'sd39};
    vecs[1] = '{16'sd32767,  16'sd8192,   16'sd0,      16'sd32767,  16'sd8192,   16'sd255};
    vecs[2] = '{16'sd100,    16'sd0,      16'sd0,      16'sd100,    16'sd0,      -16'sd127};
    vecs[3] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32257};
    vecs[4] = '{16'sd0,      16'sd0,      16'sd8192,   16'sd0,      16'sd128,    16'sd7987};

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_valid", valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_x", x_o, 0);
    check("reset_count", count_o, 0);

    // table: sample 0, one step, then stop after the step-1 transfer
    for (int i = 0; i < 5; i++) begin
      step();
      ready_i = 1'b1;
      run_i = 1'b1;
      exp_q.push_back({vecs[i].x0, vecs[i].y0, vecs[i].z0});
      exp_q.push_back({vecs[i].s1x, vecs[i].s1y, vecs[i].s1z});
      start_load(vecs[i].x0, vecs[i].y0, vecs[i].z0);
      wait_valid("load_latency", 2);
      check("s0_count", count_o, 0);
      step();
      run_i = 1'b0;
      wait_valid("step_latency", 4);
      check("s1_count", count_o, 1);
      step();
      @(negedge clk);
      check("stop_busy", busy_o, 0);
      check("stop_valid", valid_o, 0);
      check("stop_count", count_o, 2);
      check("stop_x_kept", x_o, vecs[i].s1x);
      check("stop_y_kept", y_o, vecs[i].s1y);
      check("stop_z_kept", z_o, vecs[i].s1z);
      repeat (3) @(negedge clk);
      check("stop_no_valid", valid_o, 0);
    end

    // backpressure over a longer trajectory
    step();
    ready_i = 1'b1;
    run_i = 1'b1;
    exp_q.push_back({16'sd0, -16'sd5734, 16'sd0});
    exp_q.push_back({-16'sd90, -16'sd5734, -16'sd39});
    exp_q.push_back({-16'sd180, -16'sd5735, -16'sd76});
    exp_q.push_back({-16'sd270, -16'sd5737, -16'sd111});
    start_load(16'sd0, -16'sd5734, 16'sd0);
    wait_valid("bp_load_latency", 2);
    step();
    ready_i = 1'b0;
    wait_valid("bp_step_latency", 4);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_valid_held", valid_o, 1);
      check("bp_x_held", x_o, -90);
      check("bp_z_held", z_o, -39);
    end
    check("bp_count_held", count_o, 1);
    step();
    ready_i = 1'b1;
    step();
    check("bp_one_transfer", count_o, 2);
    wait_valid("bp_s2_latency", 4);
    check("bp_s2_count", count_o, 2);
    step();
    run_i = 1'b0;
    wait_valid("bp_s3_latency", 4);
    check("bp_s3_count", count_o, 3);
    step();
    @(negedge clk);
    check("bp_stop_busy", busy_o, 0);

    // restart during CALC2
    step();
    ready_i = 1'b1;
    run_i = 1'b1;
    exp_q.push_back({16'sd0, -16'sd5734, 16'sd0});
    start_load(16'sd0, -16'sd5734, 16'sd0);
    wait_valid("rs_load_latency", 2);
    step();
    step();
    run_i = 1'b0;
    exp_q.push_back({16'sd100, 16'sd0, 16'sd0});
    start_load(16'sd100, 16'sd0, 16'sd0);
    wait_valid("rs_restart_latency", 2);
    check("rs_count", count_o, 0);
    check("rs_x", x_o, 100);
    check("rs_y", y_o, 0);
    step();
    @(negedge clk);
    check("rs_stop_busy", busy_o, 0);
    check("rs_stop_count", count_o, 1);

    // run low at start: sample 0 only
    step();
    ready_i = 1'b1;
    run_i = 1'b0;
    exp_q.push_back({16'sd0, 16'sd0, 16'sd8192});
    start_load(16'sd0, 16'sd0, 16'sd8192);
    wait_valid("rl_load_latency", 2);
    step();
    @(negedge clk);
    check("rl_busy", busy_o, 0);
    check("rl_valid", valid_o, 0);
    check("rl_count", count_o, 1);
    check("rl_z_kept", z_o, 8192);

    // reset held 3 cycles mid-HOLD, with start in the first reset cycle
    step();
    ready_i = 1'b0;
    run_i = 1'b1;
    start_load(16'sd32767, 16'sd8192, 16'sd0);
    wait_valid("mr_load_latency", 2);
    step();
    rst_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("mr_valid", valid_o, 0);
    check("mr_busy", busy_o, 0);
    check("mr_x", x_o, 0);
    check("mr_y", y_o, 0);
    check("mr_z", z_o, 0);
    check("mr_count", count_o, 0);
    repeat (3) @(negedge clk);
    check("mr_start_ignored", busy_o, 0);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
